// File: rtl/tour_monitor.sv
// Knight's Tour run monitor: decodes one-hot moves, predicts the next board
// position, checks reported xx/yy per response and latches the first error code.
module tour_monitor #(
  parameter int unsigned       BOARD    = 5,
  parameter int unsigned       POS_W    = 15,
  parameter int unsigned       SQ_SHIFT = 12,
  parameter logic [POS_W-1:0]  TOL      = 'h0300,
  parameter int unsigned       TIMEOUT  = 1_000_000,
  parameter int unsigned       CHK_MODE = 1
) (
  input  logic                            clk,
  input  logic                            RST_n,
  input  logic                            clr,
  input  logic [7:0]                      move,
  input  logic                            move_vld,
  input  logic [POS_W-1:0]                xx,
  input  logic [POS_W-1:0]                yy,
  input  logic [7:0]                      resp,
  input  logic                            resp_rdy,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [2:0]                      err_code,
  output logic [$clog2(BOARD*BOARD)-1:0]  move_cnt
);

  localparam int unsigned EW = POS_W + 2;
  localparam int unsigned MW = $clog2(BOARD*BOARD);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [MW-1:0]        LAST   = MW'(BOARD*BOARD - 1);
  localparam logic [TW-1:0]        T_TERM = TW'(TIMEOUT - 1);
  localparam logic signed [EW-1:0] MAX_SQ = EW'(BOARD - 1);
  localparam logic [EW-1:0]        TOL_X  = EW'(TOL);

  typedef enum logic [2:0] {IDLE, ARMED, WAIT_RESP, DONE, ERROR} state_t;

  state_t                 state, state_nxt;
  logic signed [EW-1:0]   exp_x, exp_y, exp_x_nxt, exp_y_nxt;
  logic                   leg, leg_nxt;
  logic [TW-1:0]          tcnt, tcnt_nxt;
  logic [MW-1:0]          cnt_nxt, cnt_inc;
  logic [2:0]             code_nxt, fault;

  logic signed [2:0]      dx, dy;
  logic signed [EW-1:0]   pos_x, pos_y, cap_x, cap_y, sq_x, sq_y;
  logic signed [EW-1:0]   dif_x, dif_y;
  logic [EW-1:0]          abs_x, abs_y;
  logic                   one_hot, off_board, pass_x, pass_y, chk_x, chk_y;

  always_comb begin
    dx = '0;
    dy = '0;
    case (move)
      8'h01:   begin dx =  3'sd1; dy =  3'sd2; end
      8'h02:   begin dx = -3'sd1; dy =  3'sd2; end
      8'h04:   begin dx = -3'sd2; dy =  3'sd1; end
      8'h08:   begin dx = -3'sd2; dy = -3'sd1; end
      8'h10:   begin dx = -3'sd1; dy = -3'sd2; end
      8'h20:   begin dx =  3'sd1; dy = -3'sd2; end
      8'h40:   begin dx =  3'sd2; dy = -3'sd1; end
      8'h80:   begin dx =  3'sd2; dy =  3'sd1; end
      default: begin dx = '0;     dy = '0;     end
    endcase
  end

  // Board coordinates are never negative, so xx/yy are widened as magnitudes;
  // this lets a 5x5 board at 0x1000 per square fit in 15 bits.
  assign pos_x     = $signed({2'b00, xx});
  assign pos_y     = $signed({2'b00, yy});
  assign one_hot   = $onehot(move);
  assign cap_x     = pos_x + (EW'(dx) <<< SQ_SHIFT);
  assign cap_y     = pos_y + (EW'(dy) <<< SQ_SHIFT);
  assign sq_x      = cap_x >>> SQ_SHIFT;
  assign sq_y      = cap_y >>> SQ_SHIFT;
  assign off_board = sq_x[EW-1] || (sq_x > MAX_SQ) || sq_y[EW-1] || (sq_y > MAX_SQ);

  assign dif_x  = exp_x - pos_x;
  assign dif_y  = exp_y - pos_y;
  assign abs_x  = dif_x[EW-1] ? -dif_x : dif_x;
  assign abs_y  = dif_y[EW-1] ? -dif_y : dif_y;
  assign pass_x = abs_x < TOL_X;
  assign pass_y = abs_y < TOL_X;
  assign chk_y  = (CHK_MODE == 0) || !leg;
  assign chk_x  = (CHK_MODE == 0) || leg;
  assign cnt_inc = move_cnt + 1'b1;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state    <= IDLE;
      exp_x    <= '0;
      exp_y    <= '0;
      leg      <= 1'b0;
      tcnt     <= '0;
      move_cnt <= '0;
      err_code <= '0;
    end else begin
      state    <= state_nxt;
      exp_x    <= exp_x_nxt;
      exp_y    <= exp_y_nxt;
      leg      <= leg_nxt;
      tcnt     <= tcnt_nxt;
      move_cnt <= cnt_nxt;
      err_code <= code_nxt;
    end
  end

  // Error sources are tested in ascending code order so the lowest code wins.
  always_comb begin
    state_nxt = state;
    exp_x_nxt = exp_x;
    exp_y_nxt = exp_y;
    leg_nxt   = leg;
    tcnt_nxt  = tcnt;
    cnt_nxt   = move_cnt;
    code_nxt  = err_code;
    fault     = '0;
    if (clr) begin
      state_nxt = IDLE;
      exp_x_nxt = '0;
      exp_y_nxt = '0;
      leg_nxt   = 1'b0;
      tcnt_nxt  = '0;
      cnt_nxt   = '0;
      code_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (resp_rdy && (resp == 8'h5A)) state_nxt = ARMED;
        end
        ARMED: begin
          if (move_vld && !one_hot)       fault = 3'd1;
          else if (move_vld && off_board) fault = 3'd2;
          else if (resp_rdy)              fault = 3'd7;
          if (fault != '0) begin
            state_nxt = ERROR;
            code_nxt  = fault;
          end else if (move_vld) begin
            state_nxt = WAIT_RESP;
            exp_x_nxt = cap_x;
            exp_y_nxt = cap_y;
            leg_nxt   = 1'b0;
            tcnt_nxt  = '0;
          end
        end
        WAIT_RESP: begin
          if (resp_rdy && chk_x && !pass_x)      fault = 3'd3;
          else if (resp_rdy && chk_y && !pass_y) fault = 3'd4;
          else if (resp_rdy && resp != 8'hA5)    fault = 3'd5;
          else if (!resp_rdy && tcnt == T_TERM)  fault = 3'd6;
          else if (move_vld)                     fault = 3'd7;
          if (fault != '0) begin
            state_nxt = ERROR;
            code_nxt  = fault;
          end else if (resp_rdy) begin
            tcnt_nxt = '0;
            if ((CHK_MODE != 0) && !leg) begin
              leg_nxt = 1'b1;
            end else begin
              leg_nxt   = 1'b0;
              cnt_nxt   = cnt_inc;
              state_nxt = (cnt_inc == LAST) ? DONE : ARMED;
            end
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
        DONE:    state_nxt = DONE;
        ERROR:   state_nxt = ERROR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == ARMED) || (state == WAIT_RESP);
    done = (state == DONE);
    err  = (state == ERROR);
  end

endmodule

// File: tb/tb_tour_monitor.sv
// Directed bench for tour_monitor: vector table for single-cycle behaviour,
// hand sequences for async reset, timeout and full tours in both check modes.
module tb_tour_monitor;

  logic        clk = 1'b0;
  logic        RST_n = 1'b0;
  logic        clr = 1'b0;
  logic        move_vld = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [7:0]  move = '0;
  logic [7:0]  resp = '0;
  logic [14:0] xx = '0;
  logic [14:0] yy = '0;

  logic        busy1, done1, err1, busy0, done0, err0;
  logic [2:0]  code1, code0;
  logic [4:0]  cnt1, cnt0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tour_monitor #(.TIMEOUT(100), .CHK_MODE(1)) u_dut1 (
    .clk(clk), .RST_n(RST_n), .clr(clr), .move(move), .move_vld(move_vld),
    .xx(xx), .yy(yy), .resp(resp), .resp_rdy(resp_rdy),
    .busy(busy1), .done(done1), .err(err1), .err_code(code1), .move_cnt(cnt1)
  );

  tour_monitor #(.TIMEOUT(100), .CHK_MODE(0)) u_dut0 (
    .clk(clk), .RST_n(RST_n), .clr(clr), .move(move), .move_vld(move_vld),
    .xx(xx), .yy(yy), .resp(resp), .resp_rdy(resp_rdy),
    .busy(busy0), .done(done0), .err(err0), .err_code(code0), .move_cnt(cnt0)
  );

  typedef struct {
    logic        c;
    logic        mv;
    logic [7:0]  m;
    int          x;
    int          y;
    logic        rr;
    logic [7:0]  r;
    logic [10:0] exp;
  } vec_t;

  vec_t vt[$];

  function automatic logic [10:0] E(logic b, logic d, logic e, logic [2:0] c, logic [4:0] n);
    return {b, d, e, c, n};
  endfunction

  function void add(logic c, logic mv, logic [7:0] m, int x, int y,
                    logic rr, logic [7:0] r, logic [10:0] exp);
    vec_t v;
    v.c = c; v.mv = mv; v.m = m; v.x = x; v.y = y; v.rr = rr; v.r = r; v.exp = exp;
    vt.push_back(v);
  endfunction

  function automatic logic [10:0] st1();
    return {busy1, done1, err1, code1, cnt1};
  endfunction

  function automatic logic [10:0] st0();
    return {busy0, done0, err0, code0, cnt0};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step(input logic c, input logic mv, input logic [7:0] m, input int x,
                      input int y, input logic rr, input logic [7:0] r);
    @(negedge clk);
    clr = c; move_vld = mv; move = m; xx = 15'(x); yy = 15'(y); resp_rdy = rr; resp = r;
    @(posedge clk);
    #1;
    clr = 1'b0; move_vld = 1'b0; resp_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 8'h00, 0, 0, 0, 8'h00);
  endtask

  task automatic knight(input logic [7:0] m, output int dx, output int dy);
    case (m)
      8'h01: begin dx =  1; dy =  2; end
      8'h02: begin dx = -1; dy =  2; end
      8'h04: begin dx = -2; dy =  1; end
      8'h08: begin dx = -2; dy = -1; end
      8'h10: begin dx = -1; dy = -2; end
      8'h20: begin dx =  1; dy = -2; end
      8'h40: begin dx =  2; dy = -1; end
      default: begin dx =  2; dy =  1; end
    endcase
  endtask

  // 24 moves cycling a closed 4-move loop; reported positions sit 0x2FF off.
  task automatic run_tour(input int mode, input int sx, input int sy,
                          input logic [7:0] c0, input logic [7:0] c1,
                          input logic [7:0] c2, input logic [7:0] c3);
    logic [7:0] cyc [4];
    logic [10:0] s;
    int px, py, ex, ey, dx, dy, off;
    cyc[0] = c0; cyc[1] = c1; cyc[2] = c2; cyc[3] = c3;
    step(1, 0, 8'h00, 0, 0, 0, 8'h00);
    step(0, 0, 8'h00, 0, 0, 1, 8'h5A);
    px = sx * 4096 + 'h800;
    py = sy * 4096 + 'h800;
    for (int i = 0; i < 24; i++) begin
      knight(cyc[i % 4], dx, dy);
      ex  = px + dx * 4096;
      ey  = py + dy * 4096;
      off = (i % 2 == 1) ? 'h2FF : -'h2FF;
      step(0, 1, cyc[i % 4], px, py, 0, 8'h00);
      if (mode == 1) begin
        step(0, 0, 8'h00, px, ey + off, 1, 8'hA5);
        step(0, 0, 8'h00, ex - off, ey, 1, 8'hA5);
      end else begin
        step(0, 0, 8'h00, ex - off, ey + off, 1, 8'hA5);
      end
      s = (mode == 1) ? st1() : st0();
      check($sformatf("tour_m%0d_cnt%0d", mode, i + 1), s[4:0], i + 1);
      px = ex;
      py = ey;
    end
    s = (mode == 1) ? st1() : st0();
    check($sformatf("tour_m%0d_done", mode), s, E(0, 1, 0, 3'd0, 5'd24));
    step(0, 1, 8'h01, px, py, 1, 8'h5A);
    s = (mode == 1) ? st1() : st0();
    check($sformatf("tour_m%0d_done_hold", mode), s, E(0, 1, 0, 3'd0, 5'd24));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Row-per-cycle vectors on the CHK_MODE=1 instance.
    add(0,0,8'h00,0,0,0,8'h00,       E(0,0,0,3'd0,5'd0));
    add(0,1,8'h01,'h2800,'h2800,0,0, E(0,0,0,3'd0,5'd0));
    add(0,0,8'h00,0,0,1,8'h5A,       E(1,0,0,3'd0,5'd0));
    add(0,1,8'h01,'h2800,'h2800,0,0, E(1,0,0,3'd0,5'd0));
    add(0,0,8'h00,0,'h4850,1,8'hA5,  E(1,0,0,3'd0,5'd0));
    add(0,0,8'h00,'h37A0,'h4850,1,8'hA5, E(1,0,0,3'd0,5'd1));
    add(0,0,8'h00,0,0,0,8'h00,       E(1,0,0,3'd0,5'd1));
    add(1,0,8'h00,0,0,0,8'h00,       E(0,0,0,3'd0,5'd0));
    add(0,0,8'h00,0,0,1,8'h5A,       E(1,0,0,3'd0,5'd0));
    add(0,1,8'h01,'h2800,'h2800,0,0, E(1,0,0,3'd0,5'd0));
    add(0,0,8'h00,0,'h4400,1,8'hA5,  E(0,0,1,3'd4,5'd0));
    add(0,0,8'h00,0,0,0,8'h00,       E(0,0,1,3'd4,5'd0));
    add(0,0,8'h00,0,0,1,8'h5A,       E(0,0,1,3'd4,5'd0));
    add(0,1,8'h01,'h2800,'h2800,0,0, E(0,0,1,3'd4,5'd0));
    add(1,0,8'h00,0,0,0,8'h00,       E(0,0,0,3'd0,5'd0));
    add(0,0,8'h00,0,0,1,8'h5A,       E(1,0,0,3'd0,5'd0));
    add(0,1,8'h03,'h2800,'h2800,0,0, E(0,0,1,3'd1,5'd0));
    add(1,0,8'h00,0,0,0,8'h00,       E(0,0,0,3'd0,5'd0));
    add(0,0,8'h00,0,0,1,8'h5A,       E(1,0,0,3'd0,5'd0));
    add(0,1,8'h04,'h0800,'h2800,0,0, E(0,0,1,3'd2,5'd0));
    add(1,0,8'h00,0,0,0,8'h00,       E(0,0,0,3'd0,5'd0));
    add(0,0,8'h00,0,0,1,8'h5A,       E(1,0,0,3'd0,5'd0));
    add(0,0,8'h00,0,0,1,8'hA5,       E(0,0,1,3'd7,5'd0));
    add(1,0,8'h00,0,0,0,8'h00,       E(0,0,0,3'd0,5'd0));
    add(0,0,8'h00,0,0,1,8'h5A,       E(1,0,0,3'd0,5'd0));
    add(0,1,8'h01,'h2800,'h2800,1,8'hA5, E(0,0,1,3'd7,5'd0));
    add(1,0,8'h00,0,0,0,8'h00,       E(0,0,0,3'd0,5'd0));
    add(0,0,8'h00,0,0,1,8'h5A,       E(1,0,0,3'd0,5'd0));
    add(0,1,8'h03,'h2800,'h2800,1,8'hA5, E(0,0,1,3'd1,5'd0));
    add(1,0,8'h00,0,0,0,8'h00,       E(0,0,0,3'd0,5'd0));
    add(0,0,8'h00,0,0,1,8'h5A,       E(1,0,0,3'd0,5'd0));
    add(0,1,8'h01,'h2800,'h2800,0,0, E(1,0,0,3'd0,5'd0));
    add(0,1,8'h01,'h2800,'h2800,0,0, E(0,0,1,3'd7,5'd0));
    add(1,0,8'h00,0,0,0,8'h00,       E(0,0,0,3'd0,5'd0));
    add(0,0,8'h00,0,0,1,8'h5A,       E(1,0,0,3'd0,5'd0));
    add(0,1,8'h01,'h2800,'h2800,0,0, E(1,0,0,3'd0,5'd0));
    add(0,0,8'h00,0,'h4501,1,8'hA5,  E(1,0,0,3'd0,5'd0));
    add(0,0,8'h00,'h3B00,'h4501,1,8'hA5, E(0,0,1,3'd3,5'd0));
    add(1,0,8'h00,0,0,0,8'h00,       E(0,0,0,3'd0,5'd0));
    add(0,0,8'h00,0,0,1,8'h5A,       E(1,0,0,3'd0,5'd0));
    add(0,1,8'h01,'h2800,'h2800,0,0, E(1,0,0,3'd0,5'd0));
    add(0,0,8'h00,0,'h4800,1,8'hA4,  E(0,0,1,3'd5,5'd0));
    add(1,0,8'h00,0,0,1,8'h5A,       E(0,0,0,3'd0,5'd0));
    add(0,0,8'h00,0,0,0,8'h00,       E(0,0,0,3'd0,5'd0));
    add(0,0,8'h00,0,0,1,8'h5B,       E(0,0,0,3'd0,5'd0));
    add(0,0,8'h00,0,0,1,8'h5A,       E(1,0,0,3'd0,5'd0));
    add(0,1,8'h80,'h4800,'h0800,0,0, E(0,0,1,3'd2,5'd0));
    add(1,0,8'h00,0,0,0,8'h00,       E(0,0,0,3'd0,5'd0));

    repeat (2) @(posedge clk);
    #1;
    check("reset_m1", st1(), E(0,0,0,3'd0,5'd0));
    check("reset_m0", st0(), E(0,0,0,3'd0,5'd0));
    @(negedge clk);
    RST_n = 1'b1;

    foreach (vt[i]) begin
      step(vt[i].c, vt[i].mv, vt[i].m, vt[i].x, vt[i].y, vt[i].rr, vt[i].r);
      check($sformatf("row%0d", i), st1(), vt[i].exp);
    end

    // Single-response mode: both axes checked at once, lowest code wins.
    step(0, 0, 8'h00, 0, 0, 1, 8'h5A);
    step(0, 1, 8'h01, 'h2800, 'h2800, 0, 8'h00);
    step(0, 0, 8'h00, 'h3850, 'h47B0, 1, 8'hA5);
    check("m0_good_move", st0(), E(1,0,0,3'd0,5'd1));
    step(1, 0, 8'h00, 0, 0, 0, 8'h00);
    step(0, 0, 8'h00, 0, 0, 1, 8'h5A);
    step(0, 1, 8'h01, 'h2800, 'h2800, 0, 8'h00);
    step(0, 0, 8'h00, 'h3B00, 'h4400, 1, 8'hA5);
    check("m0_both_bad", st0(), E(0,0,1,3'd3,5'd0));
    step(1, 0, 8'h00, 0, 0, 0, 8'h00);
    step(0, 0, 8'h00, 0, 0, 1, 8'h5A);
    step(0, 1, 8'h01, 'h2800, 'h2800, 0, 8'h00);
    step(0, 0, 8'h00, 'h3800, 'h4400, 1, 8'hA5);
    check("m0_y_bad", st0(), E(0,0,1,3'd4,5'd0));

    // Asynchronous reset in mid-tour, then a move pulse in IDLE.
    step(1, 0, 8'h00, 0, 0, 0, 8'h00);
    step(0, 0, 8'h00, 0, 0, 1, 8'h5A);
    step(0, 1, 8'h01, 'h2800, 'h2800, 0, 8'h00);
    step(0, 0, 8'h00, 'h3800, 'h4800, 1, 8'hA5);
    step(0, 0, 8'h00, 'h3800, 'h4800, 1, 8'hA5);
    check("pre_async_rst", st1(), E(1,0,0,3'd0,5'd1));
    @(negedge clk);
    #2 RST_n = 1'b0;
    #1;
    check("async_rst", st1(), E(0,0,0,3'd0,5'd0));
    @(negedge clk);
    RST_n = 1'b1;
    step(0, 1, 8'h01, 'h2800, 'h2800, 0, 8'h00);
    check("idle_move_ignored", st1(), E(0,0,0,3'd0,5'd0));

    // Timeout: WAIT_RESP entered at edge 0, error latched at edge 100.
    step(0, 0, 8'h00, 0, 0, 1, 8'h5A);
    step(0, 1, 8'h01, 'h2800, 'h2800, 0, 8'h00);
    idle(99);
    check("timeout_edge99", st1(), E(1,0,0,3'd0,5'd0));
    idle(1);
    check("timeout_edge100", st1(), E(0,0,1,3'd6,5'd0));
    step(1, 0, 8'h00, 0, 0, 0, 8'h00);
    step(0, 0, 8'h00, 0, 0, 1, 8'h5A);
    step(0, 1, 8'h01, 'h2800, 'h2800, 0, 8'h00);
    idle(99);
    step(0, 0, 8'h00, 0, 'h4800, 1, 8'hA5);
    check("resp_on_terminal", st1(), E(1,0,0,3'd0,5'd0));
    step(0, 0, 8'h00, 'h3800, 'h4800, 1, 8'hA5);
    check("resp_on_terminal_x", st1(), E(1,0,0,3'd0,5'd1));

    run_tour(1, 1, 0, 8'h01, 8'h80, 8'h10, 8'h08);
    run_tour(0, 3, 0, 8'h02, 8'h04, 8'h20, 8'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
